// File: rtl/vga_timing_gen.sv
// VGA timing generator: sync, blanking, pixel position and pixel-request
// strobes for an arbitrary timing set, all in the pixel clock domain.
// Each line and frame is ordered FRONT, SYNC, BACK, DISPLAY.
module vga_timing_gen #(
  parameter int          COLOR_W    = 8,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          H_DISPLAY  = 640,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33,
  parameter int          V_DISPLAY  = 480,
  parameter int          CNT_W      = 10,
  parameter int          PRE_LEAD   = 2,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter logic [23:0] BORDER_RGB = 24'hFFFF00
) (
  input  logic               clk25,
  input  logic               rstN,
  input  logic               enable,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic               clearErr,
  input  logic [COLOR_W-1:0] inRed,
  input  logic [COLOR_W-1:0] inGreen,
  input  logic [COLOR_W-1:0] inBlue,
  output logic [CNT_W-1:0]   outX,
  output logic [CNT_W-1:0]   outY,
  output logic               outRequest,
  output logic               preRequest,
  output logic               frameStart,
  output logic               lineStart,
  output logic               running,
  output logic               underflow,
  output logic [COLOR_W-1:0] outRed,
  output logic [COLOR_W-1:0] outGreen,
  output logic [COLOR_W-1:0] outBlue,
  output logic               hs,
  output logic               vs,
  output logic               vgaClk,
  output logic               vgaBlankN,
  output logic               vgaSyncN
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_DISPLAY;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_DISPLAY;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLANK_C = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] V_BLANK_C = CNT_W'(V_BLANK);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_FRONT);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_FRONT);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] PRE_START = CNT_W'(H_BLANK - PRE_LEAD);
  localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(H_TOTAL - PRE_LEAD - 1);

  // Only the top COLOR_W bits of each border byte reach the DAC.
  localparam logic [COLOR_W-1:0] BORDER_R = BORDER_RGB[23 -: COLOR_W];
  localparam logic [COLOR_W-1:0] BORDER_G = BORDER_RGB[15 -: COLOR_W];
  localparam logic [COLOR_W-1:0] BORDER_B = BORDER_RGB[7  -: COLOR_W];

  typedef enum logic [1:0] {IDLE, WAIT_FILL, RUN} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] hCount, vCount, hNext, vNext;
  logic             hsNext, vsNext, active;

  // Next-state logic: a frame, once started, always runs to its last pixel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    nextState = state;
    case (state)
      IDLE:      if (enable) nextState = WAIT_FILL;
      WAIT_FILL: if (!enable) nextState = IDLE;
                 else if (fifo_full) nextState = RUN;
      RUN:       if (!enable && hCount == H_LAST && vCount == V_LAST) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Next counter values; both counters sit at zero whenever not running.
  always_comb begin
    hNext = '0;
    vNext = '0;
    if (state == RUN && nextState == RUN) begin
      if (hCount == H_LAST) begin
        vNext = (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        hNext = hCount + 1'b1;
        vNext = vCount;
      end
    end
  end

  // Syncs are decoded from the next count so the registered outputs line up with it.
  always_comb begin
    hsNext = ~HS_POL;
    vsNext = ~VS_POL;
    if (nextState == RUN) begin
      if (hNext >= HS_START && hNext <= HS_END) hsNext = HS_POL;
      if (vNext >= VS_START && vNext <= VS_END) vsNext = VS_POL;
    end
  end

  // State, counters and sync registers.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state  <= IDLE;
      hCount <= '0;
      vCount <= '0;
      hs     <= ~HS_POL;
      vs     <= ~VS_POL;
    end else begin
      state  <= nextState;
      hCount <= hNext;
      vCount <= vNext;
      hs     <= hsNext;
      vs     <= vsNext;
    end
  end

  // Sticky underflow: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN)                      underflow <= 1'b0;
    else if (active && fifo_empty)  underflow <= 1'b1;
    else if (clearErr)              underflow <= 1'b0;
  end

  assign running    = (state == RUN);
  assign active     = running && (hCount >= H_BLANK_C) && (vCount >= V_BLANK_C);
  assign outRequest = active;
  assign preRequest = running && (vCount >= V_BLANK_C) &&
                      (hCount >= PRE_START) && (hCount <= PRE_END);
  assign lineStart  = running && (hCount == '0);
  assign frameStart = lineStart && (vCount == '0);
  assign outX       = active ? hCount - H_BLANK_C : '0;
  assign outY       = (vCount >= V_BLANK_C) ? vCount - V_BLANK_C : '0;
  assign outRed     = active ? inRed   : BORDER_R;
  assign outGreen   = active ? inGreen : BORDER_G;
  assign outBlue    = active ? inBlue  : BORDER_B;
  assign vgaBlankN  = active;
  assign vgaSyncN   = 1'b1;
  assign vgaClk     = ~clk25;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (instance A) and a tiny
// active-high timing set (instance B), compared against a cycle model.
module tb_vga_timing_gen;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic       rstN, enA, fullA, enB, fullB, fifo_empty, clearErr;
  logic [7:0] inRed, inGreen, inBlue;

  logic [9:0] xA, yA, xB, yB;
  logic       reqA, preA, fsA, lsA, runA, ufA, hsA, vsA, vclkA, blankNA, syncNA;
  logic       reqB, preB, fsB, lsB, runB, ufB, hsB, vsB, vclkB, blankNB, syncNB;
  logic [7:0] rA, gA, bA, rB, gB, bB;
  logic [51:0] vecA, vecB;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int startA = 0;
  int startB = 0;

  vga_timing_gen dutA (
    .clk25(clk25), .rstN(rstN), .enable(enA), .fifo_full(fullA),
    .fifo_empty(fifo_empty), .clearErr(clearErr),
    .inRed(inRed), .inGreen(inGreen), .inBlue(inBlue),
    .outX(xA), .outY(yA), .outRequest(reqA), .preRequest(preA),
    .frameStart(fsA), .lineStart(lsA), .running(runA), .underflow(ufA),
    .outRed(rA), .outGreen(gA), .outBlue(bA), .hs(hsA), .vs(vsA),
    .vgaClk(vclkA), .vgaBlankN(blankNA), .vgaSyncN(syncNA)
  );

  vga_timing_gen #(
    .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_DISPLAY(8),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_DISPLAY(4),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dutB (
    .clk25(clk25), .rstN(rstN), .enable(enB), .fifo_full(fullB),
    .fifo_empty(fifo_empty), .clearErr(clearErr),
    .inRed(inRed), .inGreen(inGreen), .inBlue(inBlue),
    .outX(xB), .outY(yB), .outRequest(reqB), .preRequest(preB),
    .frameStart(fsB), .lineStart(lsB), .running(runB), .underflow(ufB),
    .outRed(rB), .outGreen(gB), .outBlue(bB), .hs(hsB), .vs(vsB),
    .vgaClk(vclkB), .vgaBlankN(blankNB), .vgaSyncN(syncNB)
  );

  assign vecA = {hsA, vsA, reqA, preA, lsA, fsA, runA, blankNA, xA, yA, rA, gA, bA};
  assign vecB = {hsB, vsB, reqB, preB, lsB, fsB, runB, blankNB, xB, yB, rB, gB, bB};

  localparam logic [51:0] RST_A  = {2'b11, 6'b0, 20'd0, 8'hFF, 8'hFF, 8'h00};
  localparam logic [51:0] IDLE_B = {2'b00, 6'b0, 20'd0, 8'hFF, 8'hFF, 8'h00};

  // Expected output vector of a running controller at position (h, v).
  function automatic logic [51:0] model(input int h, input int v,
                                        input int hF, input int hS, input int hB, input int hT,
                                        input int vF, input int vS, input int vB, input int pl,
                                        input logic hp, input logic vp);
    logic act, hsE, vsE, preE;
    logic [9:0] x, y;
    act  = (h >= hB) && (v >= vB);
    hsE  = (h >= hF && h < hF + hS) ? hp : ~hp;
    vsE  = (v >= vF && v < vF + vS) ? vp : ~vp;
    preE = (v >= vB) && (h >= hB - pl) && (h <= hT - pl - 1);
    x    = act ? 10'(h - hB) : 10'd0;
    y    = (v >= vB) ? 10'(v - vB) : 10'd0;
    return {hsE, vsE, act, preE, (h == 0), (h == 0 && v == 0), 1'b1, act, x, y,
            act ? inRed : 8'hFF, act ? inGreen : 8'hFF, act ? inBlue : 8'h00};
  endfunction

  function automatic logic [51:0] modelA(input int t);
    return model(t % 800, (t / 800) % 525, 16, 96, 160, 800, 10, 2, 45, 2, 1'b0, 1'b0);
  endfunction

  function automatic logic [51:0] modelB(input int t);
    return model(t % 15, (t / 15) % 7, 2, 3, 7, 15, 1, 1, 3, 2, 1'b1, 1'b1);
  endfunction

  function automatic int hPosB();
    return (cyc - startB) % 15;
  endfunction

  function automatic int vPosB();
    return ((cyc - startB) / 15) % 7;
  endfunction

  task automatic step();
    @(negedge clk25);
    cyc++;
  endtask

  task automatic waitB(input int h, input int v);
    for (int i = 0; i < 120 && !(hPosB() == h && vPosB() == v); i++) step();
  endtask

  task automatic test_reset();
    rstN = 1'b0; enA = 1'b0; fullA = 1'b0; enB = 1'b0; fullB = 1'b0;
    fifo_empty = 1'b0; clearErr = 1'b0;
    inRed = 8'h12; inGreen = 8'h34; inBlue = 8'h56;
    step();
    step();
    checks++;
    if (vecA !== RST_A) begin errors++; $display("FAIL reset_A got %h want %h", vecA, RST_A); end
    checks++;
    if (vecB !== IDLE_B) begin errors++; $display("FAIL reset_B got %h want %h", vecB, IDLE_B); end
    checks++;
    if ({ufA, ufB, syncNA, syncNB} !== 4'b0011) begin
      errors++; $display("FAIL reset_flags got %b want 0011", {ufA, ufB, syncNA, syncNB});
    end
    checks++;
    if (vclkA !== ~clk25) begin errors++; $display("FAIL vga_clk got %b want %b", vclkA, ~clk25); end
  endtask

  task automatic test_default_timing();
    int hsLow, vsLow, firstPre;
    hsLow = 0; vsLow = 0; firstPre = -1;
    rstN = 1'b1;
    enA = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (runA !== 1'b0) begin errors++; $display("FAIL wait_fill_A got %b want 0", runA); end
    end
    fullA = 1'b1;
    step();
    fullA = 1'b0;
    startA = cyc;
    for (int t = 0; t < 46 * 800; t++) begin
      checks++;
      if (vecA !== modelA(t)) begin
        errors++; $display("FAIL timing_A t=%0d got %h want %h", t, vecA, modelA(t));
      end
      if (t < 800 && hsA == 1'b0) hsLow++;
      if (vsA == 1'b0) vsLow++;
      if (firstPre < 0 && preA == 1'b1) firstPre = t;
      step();
    end
    checks++;
    if (hsLow !== 96) begin errors++; $display("FAIL hs_width got %0d want 96", hsLow); end
    checks++;
    if (vsLow !== 1600) begin errors++; $display("FAIL vs_width got %0d want 1600", vsLow); end
    checks++;
    if (firstPre !== 45 * 800 + 158) begin
      errors++; $display("FAIL first_pre got %0d want %0d", firstPre, 45 * 800 + 158);
    end
  endtask

  task automatic test_small_timing();
    int frames, hsHigh, vsHigh;
    frames = 0; hsHigh = 0; vsHigh = 0;
    enB = 1'b1;
    step();
    fullB = 1'b1;
    step();
    fullB = 1'b0;
    startB = cyc;
    for (int t = 0; t < 315; t++) begin
      checks++;
      if (vecB !== modelB(t)) begin
        errors++; $display("FAIL timing_B t=%0d got %h want %h", t, vecB, modelB(t));
      end
      if (fsB) frames++;
      if (hsB) hsHigh++;
      if (vsB) vsHigh++;
      step();
    end
    checks++;
    if (frames !== 3) begin errors++; $display("FAIL frame_pulses got %0d want 3", frames); end
    checks++;
    if (hsHigh !== 63) begin errors++; $display("FAIL hs_high_B got %0d want 63", hsHigh); end
    checks++;
    if (vsHigh !== 45) begin errors++; $display("FAIL vs_high_B got %0d want 45", vsHigh); end
  endtask

  task automatic test_underflow();
    waitB(0, 1);
    fifo_empty = 1'b1;
    step();
    fifo_empty = 1'b0;
    checks++;
    if (ufB !== 1'b0) begin errors++; $display("FAIL uf_blank got %b want 0", ufB); end
    waitB(7, 3);
    fifo_empty = 1'b1;
    step();
    fifo_empty = 1'b0;
    checks++;
    if (ufB !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", ufB); end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (ufB !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b want 1", ufB); end
    clearErr = 1'b1;
    step();
    clearErr = 1'b0;
    checks++;
    if (ufB !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", ufB); end
    waitB(10, 4);
    fifo_empty = 1'b1;
    clearErr = 1'b1;
    step();
    fifo_empty = 1'b0;
    clearErr = 1'b0;
    checks++;
    if (ufB !== 1'b1) begin errors++; $display("FAIL uf_set_wins got %b want 1", ufB); end
    clearErr = 1'b1;
    step();
    clearErr = 1'b0;
    checks++;
    if (ufB !== 1'b0) begin errors++; $display("FAIL uf_clear2 got %b want 0", ufB); end
  endtask

  task automatic test_enable_drop();
    waitB(5, 2);
    enB = 1'b0;
    for (int i = 0; i < 120 && !(hPosB() == 14 && vPosB() == 6); i++) begin
      step();
      checks++;
      if (runB !== 1'b1) begin errors++; $display("FAIL frame_truncated i=%0d got %b want 1", i, runB); end
    end
    checks++;
    if (vecB !== modelB(104)) begin
      errors++; $display("FAIL last_pixel_B got %h want %h", vecB, modelB(104));
    end
    step();
    checks++;
    if (vecB !== IDLE_B) begin errors++; $display("FAIL stopped_B got %h want %h", vecB, IDLE_B); end
    fullB = 1'b1;
    for (int i = 0; i < 6; i++) step();
    fullB = 1'b0;
    checks++;
    if (vecB !== IDLE_B) begin errors++; $display("FAIL idle_hold_B got %h want %h", vecB, IDLE_B); end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 900 && ((cyc - startA) % 800) != 300; i++) step();
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (vecA !== RST_A) begin errors++; $display("FAIL async_reset_A got %h want %h", vecA, RST_A); end
    checks++;
    if (ufA !== 1'b0) begin errors++; $display("FAIL async_reset_uf got %b want 0", ufA); end
    step();
    rstN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({runA, lsA} !== 2'b00) begin errors++; $display("FAIL no_restart got %b want 00", {runA, lsA}); end
    end
    fullA = 1'b1;
    step();
    fullA = 1'b0;
    checks++;
    if (vecA !== modelA(0)) begin errors++; $display("FAIL restart_A got %h want %h", vecA, modelA(0)); end
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_small_timing();
    test_underflow();
    test_enable_drop();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
